// File: rtl/tx_fifo_pkt_reader_if.sv
// ----------------------------------------------------------------------------
// tx_fifo_pkt_reader_if
//
// Bundles the two data-path sides of the packet reader:
//   - read port of the upstream standard-mode FIFO (read latency 1)
//   - AXI-Stream master towards the baseband TX path
//
// Signals:
//   fifo_dout      FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty     FIFO empty flag
//   fifo_rd_en     FIFO pop request
//   m_axis_tdata   stream data
//   m_axis_tvalid  stream valid
//   m_axis_tready  stream ready (from downstream)
//   m_axis_tlast   last word of packet
//
// Modports:
//   master  the packet reader (drives fifo_rd_en and the stream)
//   slave   the environment (FIFO read side and stream sink)
// ----------------------------------------------------------------------------
interface tx_fifo_pkt_reader_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  m_axis_tready,
        output fifo_rd_en,
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        output m_axis_tready,
        input  fifo_rd_en,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast
    );
endinterface

// File: rtl/tx_fifo_pkt_reader.sv
// ----------------------------------------------------------------------------
// tx_fifo_pkt_reader
//
// Pops exactly one packet of pkt_len words from a read-latency-1 FIFO and
// presents it as an AXI-Stream master with tlast on the final word. A
// 2-entry output buffer absorbs the FIFO read latency so full throughput is
// kept under backpressure.
//
// Ports:
//   clk          read-side clock, rising edge
//   rstn         asynchronous active-low reset
//   start        one-cycle packet request, honoured only in IDLE
//   pkt_len      packet length in words, sampled with start
//   abort        synchronous flush, overrides everything but reset
//   bus          FIFO read port + AXI-Stream master (master modport)
//   busy         state != IDLE
//   done         one-cycle pulse when a packet completes
//   len_err      one-cycle pulse the cycle after start with pkt_len == 0
//   underrun_cnt saturating starvation counter (optional, see below)
//
// Optional feature macro: TX_FIFO_PKT_READER_UNDERRUN_CNT_EN
//   When defined, adds underrun_cnt: counts cycles in READ where words are
//   still owed, the FIFO is empty and the output buffer is empty.
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start
// READ  | popping words from the FIFO while req_left != 0
// DRAIN | all words requested; waiting for the last stream handshake
// DONE  | one-cycle done pulse, then back to IDLE
// ----------------------------------------------------------------------------
module tx_fifo_pkt_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] pkt_len,
    input  logic                 abort,
    tx_fifo_pkt_reader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 len_err
`ifdef TX_FIFO_PKT_READER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]          underrun_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  req_left_q, req_left_d;
    logic [LEN_WIDTH-1:0]  sent_left_q, sent_left_d;
    logic                  len_err_q, len_err_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;   // head entry
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;   // second entry
    logic [1:0]            occ_after_pop;

    logic tvalid;
    logic pop;
    logic rd_en;
    logic accept;

    assign tvalid = (occ_q != 2'd0);
    assign pop    = tvalid && bus.m_axis_tready;

    // Pop only if the word still fits once it lands: everything already in
    // the buffer plus the word in flight, minus what leaves this cycle, must
    // leave a free slot. No pop during abort so no FIFO word is lost to it.
    assign rd_en = (state_q == ST_READ) && !abort &&
                   (req_left_q != '0) && !bus.fifo_empty &&
                   (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    assign bus.fifo_rd_en    = rd_en;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tdata  = buf0_q;
    assign bus.m_axis_tlast  = tvalid && (sent_left_q == LEN_WIDTH'(1));

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign len_err = len_err_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            req_left_q  <= '0;
            sent_left_q <= '0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_left_q  <= req_left_d;
            sent_left_q <= sent_left_d;
            len_err_q   <= len_err_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        req_left_d  = req_left_q;
        sent_left_d = sent_left_q;
        len_err_d   = 1'b0;
        accept      = 1'b0;

        if (rd_en) begin
            req_left_d = req_left_q - LEN_WIDTH'(1);
        end
        if (pop && (sent_left_q != '0)) begin
            sent_left_d = sent_left_q - LEN_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (pkt_len == '0) begin
                        len_err_d = 1'b1;
                    end else begin
                        accept      = 1'b1;
                        req_left_d  = pkt_len;
                        sent_left_d = pkt_len;
                        state_d     = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (rd_en && (req_left_q == LEN_WIDTH'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave on the handshake of the last word so done lands
                // exactly one cycle after it.
                if ((sent_left_q == '0) ||
                    (pop && (sent_left_q == LEN_WIDTH'(1)))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d     = ST_IDLE;
            req_left_d  = '0;
            sent_left_d = '0;
            len_err_d   = 1'b0;
            accept      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer: 2-entry shift buffer with the head in buf0.
    // The FIFO word for a pop issued last cycle (inflight) is written to
    // the first free slot after this cycle's handshake is accounted for.
    // ------------------------------------------------------------------
    always_comb begin
        occ_d         = occ_q;
        buf0_d        = buf0_q;
        buf1_d        = buf1_q;
        inflight_d    = rd_en;
        occ_after_pop = occ_q - {1'b0, pop};

        if (abort) begin
            occ_d      = 2'd0;
            inflight_d = 1'b0;
        end else begin
            if (pop) begin
                buf0_d = buf1_q;
            end
            if (inflight_q) begin
                if (occ_after_pop == 2'd0) begin
                    buf0_d = bus.fifo_dout;
                end else begin
                    buf1_d = bus.fifo_dout;
                end
            end
            occ_d = occ_after_pop + {1'b0, inflight_q};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

`ifdef TX_FIFO_PKT_READER_UNDERRUN_CNT_EN
    // ------------------------------------------------------------------
    // Starvation counter: survives abort so software can still read why a
    // packet was abandoned; restarts on each accepted packet.
    // ------------------------------------------------------------------
    logic [15:0] underrun_cnt_q, underrun_cnt_d;
    logic        starved;

    assign starved = (state_q == ST_READ) && (req_left_q != '0) &&
                     bus.fifo_empty && (occ_q == 2'd0);

    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (accept) begin
            underrun_cnt_d = 16'd0;
        end else if (starved && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            underrun_cnt_q <= 16'd0;
        end else begin
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: doc/tx_fifo_pkt_reader.md
# tx_fifo_pkt_reader

Read-side packet reader for the tx_intf data path: pops exactly one packet of `pkt_len` words from a standard-mode (read latency 1) FIFO and presents them as an AXI-Stream master with `tlast` on the final word. It sits directly downstream of the tx_intf async data FIFO, in the read-clock domain, and feeds the baseband TX stream. Full throughput is sustained with a 2-entry output buffer that absorbs the FIFO's one-cycle read latency under backpressure.

## Interface
- `DATA_WIDTH`, 64, word width of the FIFO and stream.
- `LEN_WIDTH`, 12, width of the packet length in words.
- `clk` in 1: read-side clock; all logic on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to read a packet; sampled only in IDLE.
- `pkt_len` in LEN_WIDTH: packet length in words; sampled with `start`.
- `abort` in 1: synchronous flush; overrides everything except reset.
- `fifo_dout` in DATA_WIDTH: FIFO read data, valid the cycle after `fifo_rd_en`.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: FIFO pop request (combinational).
- `m_axis_tdata` out DATA_WIDTH: buffer head data.
- `m_axis_tvalid` out 1: buffer non-empty.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: head word is the last word of the packet.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle pulse when the packet completes.
- `len_err` out 1: one-cycle pulse when `start` arrives with `pkt_len`==0.
- `underrun_cnt` out 16: present only with the configuration macro.

## Operation
- States: IDLE, READ, DRAIN, DONE.
  - IDLE: on `start` with `pkt_len`!=0, latch `req_left`=`sent_left`=`pkt_len` and go to READ.
  - IDLE: on `start` with `pkt_len`==0, pulse `len_err` and stay in IDLE.
  - Non-IDLE: `start` is ignored.
- READ issues pops:
  - `fifo_rd_en` = READ && `req_left`!=0 && !`fifo_empty` && (occ + inflight − pop) < 2.
  - `occ` is buffer occupancy (0..2), `inflight` is the registered `fifo_rd_en`, and `pop` = `tvalid`&&`tready`.
  - Each pop decrements `req_left`. When `req_left` reaches 0, go to DRAIN.
- The cycle after a pop, `fifo_dout` is written into the buffer tail. The buffer never overflows.
- Output:
  - Head word drives `m_axis_tdata`.
  - `m_axis_tlast` = `tvalid` && `sent_left`==1.
  - Each handshake decrements `sent_left`.
- DRAIN: when `sent_left` reaches 0, go to DONE.
- DONE: pulse `done` for one cycle, then return to IDLE.
- `abort` in any state:
  - Next state is IDLE; buffer is cleared; `inflight` is cleared.
  - A FIFO word already popped is discarded.
  - No `done` pulse. `tvalid` drops even mid-handshake.
- `fifo_empty` during READ only stalls; it is never an error.

## Timing
- Reset values: `fifo_rd_en`=0, `tvalid`=0, `tlast`=0, `tdata`=0, `busy`=0, `done`=0, `len_err`=0, `underrun_cnt`=0, state IDLE.
- Latency, FIFO non-empty and `tready`=1:
  - `start` at cycle 0.
  - `busy` and `fifo_rd_en` in cycle 1.
  - First `tvalid` in cycle 3.
  - One word per cycle thereafter.
  - `done` the cycle after the `tlast` handshake.
- An N-word packet with continuous `tready` completes in N+3 cycles from `start` to `done`.
- When `pop` and a buffer write occur in the same cycle, occupancy is unchanged.
- `len_err` is asserted in the cycle after the offending `start`.

## Configuration
- `TX_FIFO_PKT_READER_UNDERRUN_CNT_EN` defined:
  - `underrun_cnt` port exists.
  - It increments, saturating at 0xFFFF, every cycle in READ with `req_left`!=0, `fifo_empty`=1 and `occ`==0 (the stream is starved).
  - It clears on `start` acceptance; it is not cleared by `abort`.
- Not defined: port and logic are absent; behaviour is otherwise identical.

## Test plan
- FIFO preloaded with words 1..4, `pkt_len`=4, `tready`=1 → `tdata` 1,2,3,4 on cycles 3–6; `tlast` only with 4; `done` in cycle 7; exactly 4 `fifo_rd_en` cycles.
- `pkt_len`=8 with `tready` toggling 1,0,1,0… → all 8 words in order, none lost or duplicated; `fifo_rd_en` never pops while occ+inflight−pop ≥ 2.
- FIFO empty for cycles 2–10 of a 3-word packet → stream stalls with `tvalid`=0; resumes after data arrives; with macro, `underrun_cnt` ≥ 8.
- `start` with `pkt_len`=0 → `len_err` pulse, `busy` stays 0, no `fifo_rd_en`; then `start` with `pkt_len`=1 → single word with `tlast`=1.
- `abort` asserted after 2 of 6 words are handshaked → next cycle `tvalid`=0, `busy`=0, no `done`; a following 2-word packet streams correctly.
- `rstn` asserted low mid-packet → all outputs at reset values immediately, asynchronously, without waiting for a clock edge.
